// File: rtl/ks_adder_arbiter.sv
// ks_adder_arbiter: shares one fixed-latency pipelined adder among NREQ requesters with per-requester credits.
// Optional macro KS_ARB_RR_EN selects round-robin arbitration; when undefined, the lowest eligible index wins.
module ks_adder_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 64,
    parameter int LAT     = 3,
    parameter int MAX_OUT = 2,
    localparam int IDW    = $clog2(NREQ),
    localparam int CW     = $clog2(MAX_OUT + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    output logic                  add_cin,
    input  logic [WIDTH-1:0]      add_sum,
    input  logic                  add_cout,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic                  busy
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);

    logic [WIDTH-1:0] r_add_a, r_add_b;
    logic             r_add_cin;
    logic [LAT:0]     r_vld_sh;
    logic [IDW-1:0]   r_id_sh [LAT+1];
    logic [NREQ-1:0]  r_rsp_valid;
    logic [IDW-1:0]   r_rsp_id;
    logic [WIDTH-1:0] r_rsp_sum;
    logic             r_rsp_cout;
    logic [CW-1:0]    r_credit [NREQ];

    logic [CW-1:0]    w_cred_eff [NREQ];
    logic [NREQ-1:0]  w_elig;
    logic [NREQ-1:0]  w_grant;
    logic             w_any;
    logic [IDW-1:0]   w_gnt_id;
    logic [WIDTH-1:0] w_op_a, w_op_b;
    logic             w_op_cin;
    int               w_base;

`ifdef KS_ARB_RR_EN
    logic [IDW-1:0]   r_ptr;
    assign w_base = int'(r_ptr);
`else
    assign w_base = 0;
`endif

    // A response leaving this cycle returns its credit immediately, so a requester at its
    // limit can be re-granted in the same cycle its result comes back (credit unchanged).
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_cred_eff[i] = r_credit[i] - CW'(r_rsp_valid[i]);
            w_elig[i]     = rst_n && req_valid[i] && (w_cred_eff[i] < MAX_C);
        end
    end

    // Handshake: a request transfers in a cycle where req_valid[i] && req_ready[i]; req_ready is
    // one-hot, recomputed every cycle, and never waits on anything but credits and arbitration.
    always_comb begin
        w_grant  = '0;
        w_gnt_id = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_grant == '0 && w_elig[(w_base + k) % NREQ]) begin
                w_grant[(w_base + k) % NREQ] = 1'b1;
                w_gnt_id = IDW'((w_base + k) % NREQ);
            end
        end
    end

    assign w_any     = |w_grant;
    assign req_ready = w_grant;

    always_comb begin
        w_op_a   = '0;
        w_op_b   = '0;
        w_op_cin = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_op_a   = req_a[i*WIDTH +: WIDTH];
                w_op_b   = req_b[i*WIDTH +: WIDTH];
                w_op_cin = req_cin[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_add_cin   <= 1'b0;
            r_vld_sh    <= '0;
            r_rsp_valid <= '0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
            r_rsp_cout  <= 1'b0;
            for (int k = 0; k <= LAT; k++) r_id_sh[k] <= '0;
            for (int i = 0; i < NREQ; i++) r_credit[i] <= '0;
`ifdef KS_ARB_RR_EN
            r_ptr       <= '0;
`endif
        end else begin
            // Operands hold when idle so the adder inputs do not toggle needlessly.
            if (w_any) begin
                r_add_a   <= w_op_a;
                r_add_b   <= w_op_b;
                r_add_cin <= w_op_cin;
            end
            // The adder cannot stall, so the shadow pipeline shifts every cycle.
            r_vld_sh   <= {r_vld_sh[LAT-1:0], w_any};
            r_id_sh[0] <= w_gnt_id;
            for (int k = 1; k <= LAT; k++) r_id_sh[k] <= r_id_sh[k-1];
            r_rsp_valid <= r_vld_sh[LAT] ? ({{(NREQ-1){1'b0}}, 1'b1} << r_id_sh[LAT]) : '0;
            r_rsp_id    <= r_id_sh[LAT];
            r_rsp_sum   <= add_sum;
            r_rsp_cout  <= add_cout;
            for (int i = 0; i < NREQ; i++) begin
                case ({w_grant[i], r_rsp_valid[i]})
                    2'b10:   r_credit[i] <= r_credit[i] + 1'b1;
                    2'b01:   r_credit[i] <= r_credit[i] - 1'b1;
                    default: r_credit[i] <= r_credit[i];
                endcase
            end
`ifdef KS_ARB_RR_EN
            if (w_any) r_ptr <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
`endif
        end
    end

    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign add_cin   = r_add_cin;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_cout  = r_rsp_cout;
    assign busy      = (|r_vld_sh) | (|r_rsp_valid);

endmodule

// File: tb/tb_ks_adder_arbiter.sv
// tb_ks_adder_arbiter: self-checking bench with a behavioural adder, an operation-queue reference model,
// a vector table, hand sequences for credits/arbitration/reset, and a randomized phase.
`timescale 1ns/1ps
module tb_ks_adder_arbiter;
    localparam int NREQ    = 4;
    localparam int W       = 64;
    localparam int LAT     = 3;
    localparam int MAX_OUT = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic [W-1:0]      add_a, add_b;
    logic              add_cin;
    logic [W-1:0]      add_sum;
    logic              add_cout;
    logic [NREQ-1:0]   rsp_valid;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic              busy;

    always #5 clk = ~clk;

    ks_adder_arbiter #(.NREQ(NREQ), .WIDTH(W), .LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .busy(busy)
    );

    // Behavioural adder: result appears LAT clocks after its operands, never reset.
    logic [W:0] add_pipe [LAT];
    always @(posedge clk) begin
        add_pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + (W+1)'(add_cin);
        for (int k = 1; k < LAT; k++) add_pipe[k] <= add_pipe[k-1];
    end
    assign add_sum  = add_pipe[LAT-1][W-1:0];
    assign add_cout = add_pipe[LAT-1][W];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit started = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h cycle=%0d", name, act, exp, cyc);
        end
    endfunction

    // Reference model: every accepted op is queued with its own sum and the cycle it must come back.
    typedef struct { int id; logic [W-1:0] sum; logic cout; int due; } op_t;
    op_t exp_q[$];
    int rr_ptr = 0;
    logic [W-1:0] exp_add_a = '0, exp_add_b = '0;
    logic exp_add_cin = 1'b0;

    always @(negedge clk) begin : model
        int cnt [NREQ];
        logic [NREQ-1:0] exp_rdy;
        int win, idx;
        logic [W:0] full;
        if (started) begin
            exp_rdy = '0;
            win = -1;
            if (rst_n) begin
                foreach (cnt[i]) cnt[i] = 0;
                foreach (exp_q[j]) cnt[exp_q[j].id]++;
                if (exp_q.size() > 0 && exp_q[0].due == cyc) cnt[exp_q[0].id]--;
                for (int k = 0; k < NREQ; k++) begin
                    idx = (rr_ptr + k) % NREQ;
                    if (win < 0 && req_valid[idx] && cnt[idx] < MAX_OUT) win = idx;
                end
                if (win >= 0) exp_rdy[win] = 1'b1;
            end
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            chk("busy", 64'(busy), 64'(exp_q.size() != 0));
            chk("add_a", add_a, exp_add_a);
            chk("add_b", add_b, exp_add_b);
            chk("add_cin", 64'(add_cin), 64'(exp_add_cin));
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                chk("rsp_valid", 64'(rsp_valid), 64'(1) << exp_q[0].id);
                chk("rsp_id", 64'(rsp_id), 64'(exp_q[0].id));
                chk("rsp_sum", rsp_sum, exp_q[0].sum);
                chk("rsp_cout", 64'(rsp_cout), 64'(exp_q[0].cout));
                void'(exp_q.pop_front());
            end else begin
                chk("rsp_valid_idle", 64'(rsp_valid), 64'd0);
            end
            if (!rst_n) begin
                exp_q.delete();
                rr_ptr = 0;
                exp_add_a = '0;
                exp_add_b = '0;
                exp_add_cin = 1'b0;
            end else if (win >= 0) begin
                full = {1'b0, req_a[win*W +: W]} + {1'b0, req_b[win*W +: W]} + (W+1)'(req_cin[win]);
                exp_q.push_back('{win, full[W-1:0], full[W], cyc + LAT + 2});
                exp_add_a = req_a[win*W +: W];
                exp_add_b = req_b[win*W +: W];
                exp_add_cin = req_cin[win];
`ifdef KS_ARB_RR_EN
                rr_ptr = (win + 1) % NREQ;
`endif
            end
        end
    end

    typedef struct { int r; logic [W-1:0] a; logic [W-1:0] b; logic cin; logic [W-1:0] sum; logic cout; } vec_t;
    vec_t vt [7];
    int exp_off [6] = '{0, 1, 5, 6, 10, 11};
`ifdef KS_ARB_RR_EN
    int exp_arb [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
`else
    int exp_arb [12] = '{0, 0, 1, 1, 2, 0, 0, 1, 1, 2, 0, 0};
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, output int acc);
        bit done = 0;
        acc = -1;
        req_a[r*W +: W] = a;
        req_b[r*W +: W] = b;
        req_cin[r] = c;
        req_valid[r] = 1'b1;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            if (req_ready[r]) begin
                acc = cyc;
                done = 1;
            end
            tick();
        end
        req_valid[r] = 1'b0;
        chk("send_accept", 64'(done), 64'd1);
    endtask

    task automatic wait_rsp(input int r, output logic [W-1:0] s, output logic co, output int rc);
        bit got = 0;
        s = '0;
        co = 1'b0;
        rc = -1;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (rsp_valid[r]) begin
                s = rsp_sum;
                co = rsp_cout;
                rc = cyc;
                got = 1;
            end
        end
        chk("rsp_seen", 64'(got), 64'd1);
        tick();
    endtask

    task automatic rand_ops();
        for (int r = 0; r < NREQ; r++) begin
            req_a[r*W +: W] = ($urandom_range(0, 3) == 0) ? '1 : {$urandom, $urandom};
            req_b[r*W +: W] = {$urandom, $urandom};
            req_cin[r] = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        int acc, rc, n, seen, start, gid;
        logic [W-1:0] s, ra, rb;
        logic co;
        logic [W:0] full;
        int offs[$];
        int gl [12];

        vt[0] = '{0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0, 1'b1};
        vt[1] = '{2, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h8000_0000_0000_0000, 1'b0};
        vt[2] = '{1, 64'h0, 64'h0, 1'b0, 64'h0, 1'b0};
        vt[3] = '{3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vt[4] = '{1, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 64'h0, 1'b1};
        vt[5] = '{0, 64'h0000_0000_1234_5678, 64'h1, 1'b1, 64'h0000_0000_1234_567A, 1'b0};
        vt[6] = '{2, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

        rst_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_cin = '0;
        repeat (2) @(posedge clk);
        #1;
        started = 1;
        req_valid = '1;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_add_a", add_a, 64'd0);
        chk("rst_add_b", add_b, 64'd0);
        chk("rst_add_cin", 64'(add_cin), 64'd0);
        chk("rst_rsp_sum", rsp_sum, 64'd0);
        chk("rst_rsp_cout", 64'(rsp_cout), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        tick();
        rst_n = 1'b1;
        req_valid = '0;
        tick();

        for (int i = 0; i < 7; i++) begin
            send_op(vt[i].r, vt[i].a, vt[i].b, vt[i].cin, acc);
            wait_rsp(vt[i].r, s, co, rc);
            chk($sformatf("vec%0d_sum", i), s, vt[i].sum);
            chk($sformatf("vec%0d_cout", i), 64'(co), 64'(vt[i].cout));
            chk($sformatf("vec%0d_latency", i), 64'(rc - acc), 64'(LAT + 2));
        end

        // Requester 1 streams: credits cap it at two in flight, refilled as each result returns.
        start = 0;
        rand_ops();
        req_valid[1] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) start = cyc;
            if (req_ready[1]) offs.push_back(cyc - start);
            tick();
            rand_ops();
        end
        req_valid = '0;
        chk("stream_count", 64'(offs.size()), 64'd6);
        for (int i = 0; i < 6 && i < offs.size(); i++)
            chk($sformatf("stream_off%0d", i), 64'(offs[i]), 64'(exp_off[i]));
        repeat (8) tick();

        // Reset two cycles after three issues: none of them may ever respond.
        n = 0;
        rand_ops();
        req_valid = 4'b0111;
        for (int t = 0; t < 10 && n < 3; t++) begin
            @(negedge clk);
            if (|(req_ready & req_valid)) n++;
            tick();
        end
        req_valid = '0;
        chk("rst_issued", 64'(n), 64'd3);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_rsp", 64'(rsp_valid), 64'd0);
        seen = 0;
        for (int t = 0; t < 8; t++) begin
            tick();
            @(negedge clk);
            if (|rsp_valid) seen++;
        end
        chk("midrst_no_rsp", 64'(seen), 64'd0);
        tick();
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        full = {1'b0, ra} + {1'b0, rb} + 65'd1;
        send_op(3, ra, rb, 1'b1, acc);
        wait_rsp(3, s, co, rc);
        chk("post_rst_sum", s, full[W-1:0]);
        chk("post_rst_cout", 64'(co), 64'(full[W]));
        repeat (3) tick();

        // All four requesters valid continuously from an idle, zero-credit state.
        req_valid = '1;
        rand_ops();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            gid = -1;
            for (int r = 0; r < NREQ; r++) if (req_ready[r]) gid = r;
            gl[c] = gid;
            tick();
            rand_ops();
        end
        req_valid = '0;
        for (int c = 0; c < 12; c++) chk($sformatf("arb_order%0d", c), 64'(gl[c]), 64'(exp_arb[c]));
        repeat (8) tick();

        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom_range(0, 15));
            rand_ops();
            rst_n = ($urandom_range(0, 59) != 0);
            tick();
        end
        rst_n = 1'b1;
        req_valid = '0;
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
